uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter: CLK_DIV, 326, sys_clk cycles per oversample tick (16 ticks per bit; 326 gives 9600 baud at 50 MHz); legal range 2..65535.
REQ-002 sys_clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 UART_RX  input  1  serial line, idle high, 8N1 frames, LSB first; asynchronous to sys_clk.
REQ-005 RX_DATA  output  8  last correctly framed byte; held until the next good frame.
REQ-006 RX_STATUS  output  1  one-sys_clk pulse when RX_DATA is updated.
REQ-007 FRAME_ERR  output  1  one-sys_clk pulse when the stop bit samples low.

Function
REQ-008 UART_RX SHALL pass a 2-flop synchronizer (rx_s) before any use; flops reset to 1.
REQ-009 Tick divider SHALL be held at 0 in IDLE; elsewhere it counts 0..CLK_DIV-1 and issues a one-cycle tick when it is at CLK_DIV-1, then wraps to 0.
REQ-010 Sample counter SHALL count ticks 0..15 within each bit, wrap to 0 at bit end, and be cleared on entry to START.
REQ-011 States: IDLE, START, DATA, STOP, BREAK; one state register.
REQ-012 IDLE: rx_s==0 -> START on the next edge, with divider, sample counter and bit index cleared.
REQ-013 START: bit value at decision tick (REQ-019) ==1 -> IDLE (glitch rejected, no output pulse); ==0 -> remain in START, then go to DATA at sample 15.
REQ-014 DATA: bit value at decision tick SHALL be shifted into bit[index] (LSB first); after sample 15 of index 7 -> STOP, otherwise index+1.
REQ-015 STOP, bit value 1 at decision tick: RX_DATA <= shift register, RX_STATUS=1 for exactly the next cycle, state -> IDLE (mid-stop-bit exit permits back-to-back frames).
REQ-016 STOP, bit value 0 at decision tick: FRAME_ERR=1 for exactly one cycle, RX_DATA unchanged, state -> BREAK.
REQ-017 BREAK: remain until rx_s==1, then -> IDLE; a line held low SHALL produce no further pulses.
REQ-018 RX_STATUS and FRAME_ERR SHALL never be asserted in the same cycle; each is a registered output.
REQ-019 Decision tick per bit: sample 7 (default) or sample 8 (REQ-024); all state transitions are confined to tick-qualified cycles except IDLE->START and BREAK->IDLE.
REQ-020 Latency: RX_STATUS asserts 1 sys_clk after the stop-bit decision tick; counted from the UART_RX falling edge this is 2 (sync) + 1 (IDLE->START) + (9*16+decision+1)*CLK_DIV + 1 cycles, +/-1.

Reset
REQ-021 reset low SHALL immediately force: state IDLE, RX_DATA=8'h00, RX_STATUS=0, FRAME_ERR=0, all counters and shift register 0, synchronizer flops 1.
REQ-022 Reset asserted mid-frame SHALL discard the partial byte; after release the receiver SHALL wait in IDLE for a fresh falling edge and SHALL NOT pulse RX_STATUS/FRAME_ERR for the aborted frame.
REQ-023 No output SHALL change in the first sys_clk after reset deassertion other than as defined by REQ-012.

Configuration
REQ-024 Macro UART_RX_MAJORITY_EN defined: bit value = 2-of-3 majority of rx_s captured at samples 6, 7, 8; decision tick = sample 8.
REQ-025 UART_RX_MAJORITY_EN undefined: bit value = rx_s at sample 7; no majority storage is synthesized.

Verification (CLK_DIV=4, one bit = 64 sys_clk)
REQ-026 Frame 0x55, stop=1 -> one RX_STATUS pulse, RX_DATA=8'h55, FRAME_ERR never asserted.
REQ-027 Back-to-back 0xA3 then 0x0F with no idle gap -> two RX_STATUS pulses about 640 cycles apart, RX_DATA 8'hA3 then 8'h0F.
REQ-028 Low glitch of 12 sys_clk on idle line -> return to IDLE, no RX_STATUS, no FRAME_ERR.
REQ-029 Frame 0x3C with stop bit driven 0, then line held low 300 cycles, then high -> one FRAME_ERR pulse, RX_DATA keeps previous value, no further pulses.
REQ-030 reset pulsed low during data bit 4 of 0xFF -> outputs 0 immediately, no pulse for that frame; next frame 0x81 -> RX_DATA=8'h81.
REQ-031 With UART_RX_MAJORITY_EN: 1-tick low spike at sample 7 of data bit 2 in 0xFF -> RX_DATA=8'hFF; without macro -> RX_DATA=8'hFB.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Serial line and received-byte signals of the UART receiver.
// master: line driver and byte consumer; slave: the receiver itself.
interface uart_receiver_if;
    logic       UART_RX;
    logic [7:0] RX_DATA;
    logic       RX_STATUS;
    logic       FRAME_ERR;

    modport master (
        output UART_RX,
        input  RX_DATA,
        input  RX_STATUS,
        input  FRAME_ERR
    );

    modport slave (
        input  UART_RX,
        output RX_DATA,
        output RX_STATUS,
        output FRAME_ERR
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling.
// Optional build macro UART_RX_MAJORITY_EN: bit value is the 2-of-3 majority of
// samples 6, 7 and 8, decided at sample 8. Without it, sample 7 decides alone.
module uart_receiver #(
    parameter int unsigned CLK_DIV = 326
) (
    input logic            sys_clk,
    input logic            reset,
    uart_receiver_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    localparam logic [15:0] DivLast = 16'(CLK_DIV - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] DecSmp = 4'd8;
`else
    localparam logic [3:0] DecSmp = 4'd7;
`endif

    state_e      state;
    logic        rx_meta;
    logic        rx_s;
    logic [15:0] div_cnt;
    logic [3:0]  smp_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        tick;
    logic        decide;
    logic        bit_val;

    assign tick   = (state != StIdle) && (div_cnt == DivLast);
    assign decide = tick && (smp_cnt == DecSmp);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] maj_q;

    // Capture samples 6 and 7; sample 8 is taken live from rx_s.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            maj_q <= 2'b00;
        end else if (tick && smp_cnt == 4'd6) begin
            maj_q[0] <= rx_s;
        end else if (tick && smp_cnt == 4'd7) begin
            maj_q[1] <= rx_s;
        end
    end

    assign bit_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s) | (maj_q[1] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.UART_RX;
            rx_s    <= rx_meta;
        end
    end

    // Oversample tick divider; parked at zero while idle.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= 16'd0;
        end else if (state == StIdle || tick) begin
            div_cnt <= 16'd0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // Frame state machine with registered byte and pulse outputs.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state         <= StIdle;
            smp_cnt       <= 4'd0;
            bit_idx       <= 3'd0;
            shift_reg     <= 8'h00;
            bus.RX_DATA   <= 8'h00;
            bus.RX_STATUS <= 1'b0;
            bus.FRAME_ERR <= 1'b0;
        end else begin
            bus.RX_STATUS <= 1'b0;
            bus.FRAME_ERR <= 1'b0;
            case (state)
                StIdle: begin
                    if (!rx_s) begin
                        state   <= StStart;
                        smp_cnt <= 4'd0;
                        bit_idx <= 3'd0;
                    end
                end
                StStart: begin
                    if (tick) begin
                        smp_cnt <= smp_cnt + 4'd1;
                        if (decide && bit_val) begin
                            state <= StIdle;  // start bit was a glitch
                        end else if (smp_cnt == 4'd15) begin
                            state <= StData;
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        smp_cnt <= smp_cnt + 4'd1;
                        if (decide) begin
                            shift_reg[bit_idx] <= bit_val;
                        end
                        if (smp_cnt == 4'd15) begin
                            if (bit_idx == 3'd7) begin
                                state <= StStop;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
                end
                StStop: begin
                    if (tick) begin
                        smp_cnt <= smp_cnt + 4'd1;
                        // Leave mid stop bit so a following start edge is not missed.
                        if (decide) begin
                            if (bit_val) begin
                                bus.RX_DATA   <= shift_reg;
                                bus.RX_STATUS <= 1'b1;
                                state         <= StIdle;
                            end else begin
                                bus.FRAME_ERR <= 1'b1;
                                state         <= StBreak;
                            end
                        end
                    end
                end
                StBreak: begin
                    if (rx_s) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver with CLK_DIV=4 (64 sys_clk per bit).
module tb_uart_receiver;

    localparam int CLK_DIV = 4;
    localparam int BIT     = 16 * CLK_DIV;
`ifdef UART_RX_MAJORITY_EN
    localparam int DEC = 8;
    localparam bit MAJ = 1'b1;
`else
    localparam int DEC = 7;
    localparam bit MAJ = 1'b0;
`endif
    // Cycles from line falling edge to RX_STATUS, +/-1.
    localparam int LAT = 2 + 1 + (9 * 16 + DEC + 1) * CLK_DIV + 1;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;

    uart_receiver_if bus ();

    uart_receiver #(.CLK_DIV(CLK_DIV)) dut (
        .sys_clk(sys_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         status_t[$];
    logic [7:0] status_d[$];
    int         ferr_n      = 0;
    bit         overlap     = 1'b0;
    bit         long_pulse  = 1'b0;
    logic       prev_st     = 1'b0;
    logic       prev_fe     = 1'b0;
    logic [7:0] last_good   = 8'h00;
    logic [7:0] snap_d;
    logic       snap_s;
    logic       snap_f;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Pulse recorder, sampled away from the active edge.
    always @(negedge sys_clk) begin
        if (bus.RX_STATUS === 1'b1) begin
            status_t.push_back(cyc);
            status_d.push_back(bus.RX_DATA);
        end
        if (bus.FRAME_ERR === 1'b1) ferr_n++;
        if (bus.RX_STATUS === 1'b1 && bus.FRAME_ERR === 1'b1) overlap = 1'b1;
        if ((bus.RX_STATUS === 1'b1 && prev_st === 1'b1) ||
            (bus.FRAME_ERR === 1'b1 && prev_fe === 1'b1)) long_pulse = 1'b1;
        prev_st = bus.RX_STATUS;
        prev_fe = bus.FRAME_ERR;
    end

    // Drive one 10-bit frame, one line level per sys_clk; optional spike / reset pulse.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int spike,
                              input int rst_at, output int t0);
        t0 = 0;
        for (int c = 0; c < 10 * BIT; c++) begin
            int   b;
            logic lvl;
            @(negedge sys_clk);
            if (c == 0) t0 = cyc;
            b = c / BIT;
            if (b == 0) lvl = 1'b0;
            else if (b <= 8) lvl = data[b-1];
            else lvl = stop;
            if (c == spike) lvl = 1'b0;
            bus.UART_RX = lvl;
            if (rst_at >= 0 && c == rst_at) begin
                reset = 1'b0;
                #1;
                snap_d = bus.RX_DATA;
                snap_s = bus.RX_STATUS;
                snap_f = bus.FRAME_ERR;
            end
            if (rst_at >= 0 && c == rst_at + 3) reset = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            bus.UART_RX = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.UART_RX = 1'b1;
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (bus.RX_DATA !== 8'h00 || bus.RX_STATUS !== 1'b0 || bus.FRAME_ERR !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got data=%h st=%b fe=%b, want 00/0/0",
                     bus.RX_DATA, bus.RX_STATUS, bus.FRAME_ERR);
        end
        repeat (5) @(negedge sys_clk);
        reset = 1'b1;
        idle(30);
        vectors++;
        if (status_t.size() !== 0 || ferr_n !== 0 || bus.RX_DATA !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_release_quiet: got st=%0d fe=%0d data=%h, want 0/0/00",
                     status_t.size(), ferr_n, bus.RX_DATA);
        end
    endtask

    task automatic test_frame_55();
        int n0, f0, t0;
        n0 = status_t.size();
        f0 = ferr_n;
        send_frame(8'h55, 1'b1, -1, -1, t0);
        idle(20);
        vectors++;
        if (status_t.size() !== n0 + 1) begin
            miscompares++;
            $display("FAIL f55_pulses: got %0d, want 1", status_t.size() - n0);
        end
        if (status_t.size() > n0) begin
            vectors++;
            if (status_d[n0] !== 8'h55) begin
                miscompares++;
                $display("FAIL f55_data: got %h, want 55", status_d[n0]);
            end
            vectors++;
            if (status_t[n0] - t0 < LAT - 1 || status_t[n0] - t0 > LAT + 1) begin
                miscompares++;
                $display("FAIL f55_latency: got %0d, want %0d+/-1", status_t[n0] - t0, LAT);
            end
        end
        vectors++;
        if (ferr_n !== f0) begin
            miscompares++;
            $display("FAIL f55_ferr: got %0d, want 0", ferr_n - f0);
        end
        last_good = 8'h55;
    endtask

    task automatic test_back_to_back();
        int n0, t0, t1;
        n0 = status_t.size();
        send_frame(8'hA3, 1'b1, -1, -1, t0);
        send_frame(8'h0F, 1'b1, -1, -1, t1);
        idle(20);
        vectors++;
        if (status_t.size() !== n0 + 2) begin
            miscompares++;
            $display("FAIL b2b_pulses: got %0d, want 2", status_t.size() - n0);
        end else begin
            vectors++;
            if (status_d[n0] !== 8'hA3 || status_d[n0+1] !== 8'h0F) begin
                miscompares++;
                $display("FAIL b2b_data: got %h %h, want a3 0f", status_d[n0], status_d[n0+1]);
            end
            vectors++;
            if (status_t[n0+1] - status_t[n0] !== t1 - t0) begin
                miscompares++;
                $display("FAIL b2b_spacing: got %0d, want %0d",
                         status_t[n0+1] - status_t[n0], t1 - t0);
            end
        end
        last_good = 8'h0F;
    endtask

    task automatic test_glitch();
        int n0, f0;
        n0 = status_t.size();
        f0 = ferr_n;
        repeat (12) begin
            @(negedge sys_clk);
            bus.UART_RX = 1'b0;
        end
        idle(300);
        vectors++;
        if (status_t.size() !== n0 || ferr_n !== f0 || bus.RX_DATA !== last_good) begin
            miscompares++;
            $display("FAIL glitch: got st=%0d fe=%0d data=%h, want 0/0/%h",
                     status_t.size() - n0, ferr_n - f0, bus.RX_DATA, last_good);
        end
    endtask

    task automatic test_frame_error();
        int n0, f0, t0;
        n0 = status_t.size();
        f0 = ferr_n;
        send_frame(8'h3C, 1'b0, -1, -1, t0);
        repeat (300) begin
            @(negedge sys_clk);
            bus.UART_RX = 1'b0;
        end
        vectors++;
        if (ferr_n !== f0 + 1 || status_t.size() !== n0) begin
            miscompares++;
            $display("FAIL ferr_pulse: got fe=%0d st=%0d, want 1/0",
                     ferr_n - f0, status_t.size() - n0);
        end
        idle(200);
        vectors++;
        if (ferr_n !== f0 + 1 || status_t.size() !== n0) begin
            miscompares++;
            $display("FAIL ferr_break_quiet: got fe=%0d st=%0d, want 1/0",
                     ferr_n - f0, status_t.size() - n0);
        end
        vectors++;
        if (bus.RX_DATA !== last_good) begin
            miscompares++;
            $display("FAIL ferr_data_held: got %h, want %h", bus.RX_DATA, last_good);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            int         n0, f0, t0;
            logic [7:0] d;
            logic       stop;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            n0   = status_t.size();
            f0   = ferr_n;
            send_frame(d, stop, -1, -1, t0);
            idle($urandom_range(4, 80));
            if (stop) last_good = d;
            vectors++;
            if (status_t.size() !== n0 + (stop ? 1 : 0) || ferr_n !== f0 + (stop ? 0 : 1)) begin
                miscompares++;
                $display("FAIL rnd%0d_pulses: got st=%0d fe=%0d, want stop=%b",
                         i, status_t.size() - n0, ferr_n - f0, stop);
            end
            vectors++;
            if (bus.RX_DATA !== last_good) begin
                miscompares++;
                $display("FAIL rnd%0d_data: got %h, want %h", i, bus.RX_DATA, last_good);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int n0, f0, t0;
        n0 = status_t.size();
        f0 = ferr_n;
        send_frame(8'hFF, 1'b1, -1, 5 * BIT + 20, t0);
        vectors++;
        if (snap_d !== 8'h00 || snap_s !== 1'b0 || snap_f !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_state: got data=%h st=%b fe=%b, want 00/0/0",
                     snap_d, snap_s, snap_f);
        end
        idle(100);
        last_good = 8'h00;
        vectors++;
        if (status_t.size() !== n0 || ferr_n !== f0 || bus.RX_DATA !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset_aborted: got st=%0d fe=%0d data=%h, want 0/0/00",
                     status_t.size() - n0, ferr_n - f0, bus.RX_DATA);
        end
        send_frame(8'h81, 1'b1, -1, -1, t0);
        idle(20);
        last_good = 8'h81;
        vectors++;
        if (status_t.size() !== n0 + 1 || bus.RX_DATA !== 8'h81) begin
            miscompares++;
            $display("FAIL midreset_next: got st=%0d data=%h, want 1/81",
                     status_t.size() - n0, bus.RX_DATA);
        end
    endtask

    task automatic test_spike();
        int         t0;
        logic [7:0] want;
        want = MAJ ? 8'hFF : 8'hFB;
        // Line low for one sys_clk, landing on sample 7 of data bit 2.
        send_frame(8'hFF, 1'b1, (16 * 3 + 7 + 1) * CLK_DIV, -1, t0);
        idle(20);
        last_good = want;
        vectors++;
        if (bus.RX_DATA !== want) begin
            miscompares++;
            $display("FAIL spike_data: got %h, want %h", bus.RX_DATA, want);
        end
    endtask

    task automatic test_pulse_shape();
        vectors++;
        if (overlap !== 1'b0 || long_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse_shape: got overlap=%b long=%b, want 0/0", overlap, long_pulse);
        end
    endtask

    initial begin
        test_reset();
        test_frame_55();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_random();
        test_reset_midframe();
        test_spike();
        test_pulse_shape();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
